uk101_rx_fifo: RTL and testbench



---
 rtl/uk101_pkg.sv | 9 +
 rtl/uk101_sync_fifo.sv | 54 +++++
 rtl/uk101_rx_fifo.sv | 158 +++++++++++++++
 tb/tb_uk101_rx_fifo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uk101_pkg.sv
// Shared types and constants for the UK101 serial receive path.
package uk101_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

endpackage

// File: rtl/uk101_sync_fifo.sv
// DEPTH x 8 first-word-fall-through FIFO; head byte is visible while non-empty.
module uk101_sync_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [7:0]             i_din,
  input  logic                   i_pop,
  output logic [7:0]             o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_dout    = r_mem[r_rd_ptr];

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/uk101_rx_fifo.sv
// UK101 serial receive front end: 16x oversampled 8N1 deframer feeding a FWFT FIFO,
// with sticky framing and overrun flags for the ACIA.
module uk101_rx_fifo
  import uk101_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   rx,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  input  logic                   rd_en,
  output logic [$clog2(DEPTH):0] level,
  output logic                   framing_err,
  output logic                   overrun,
  input  logic                   err_clr
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [1:0]    r_sync;
  logic          w_rxs;
  logic [CW-1:0] r_div;
  logic          w_tick;
  rx_state_t     r_state, w_state_nx;
  logic [3:0]    r_tcnt, w_tcnt_nx;
  logic [2:0]    r_bidx, w_bidx_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic          w_push;
  logic          w_frame_evt;
  logic          w_ovr_evt;
  logic          w_full;
  logic          w_empty;
  logic          r_ferr;
  logic          r_ovr;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_sync <= 2'b11;
    else         r_sync <= {r_sync[0], rx};
  end
  assign w_rxs = r_sync[1];

  // Free-running baud x16 divider; frames are not phase-aligned to it.
  assign w_tick = (r_div == CW'(DIV - 1));
  always_ff @(posedge sys_clk) begin
    if (sys_rst)     r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= IDLE;
      r_tcnt  <= '0;
      r_bidx  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_tcnt  <= w_tcnt_nx;
      r_bidx  <= w_bidx_nx;
    end
  end

  always_ff @(posedge sys_clk) begin
    r_shift <= w_shift_nx;
  end

  always_comb begin
    w_state_nx  = r_state;
    w_tcnt_nx   = r_tcnt;
    w_bidx_nx   = r_bidx;
    w_shift_nx  = r_shift;
    w_push      = 1'b0;
    w_frame_evt = 1'b0;
    if (w_tick) begin
      case (r_state)
        IDLE: begin
          if (!w_rxs) begin
            w_state_nx = START;
            w_tcnt_nx  = '0;
          end
        end
        START: begin
          if (r_tcnt == 4'(MID_SAMPLE - 1)) begin
            w_tcnt_nx  = '0;
            w_bidx_nx  = '0;
            w_state_nx = w_rxs ? IDLE : DATA;
          end else begin
            w_tcnt_nx = r_tcnt + 1'b1;
          end
        end
        DATA: begin
          if (r_tcnt == 4'(OVERSAMPLE - 1)) begin
            w_tcnt_nx  = '0;
            w_shift_nx = {w_rxs, r_shift[7:1]};
            w_bidx_nx  = r_bidx + 1'b1;
            if (r_bidx == 3'd7) w_state_nx = STOP;
          end else begin
            w_tcnt_nx = r_tcnt + 1'b1;
          end
        end
        STOP: begin
          if (r_tcnt == 4'(OVERSAMPLE - 1)) begin
            w_tcnt_nx = '0;
            if (w_rxs) begin
              w_push     = 1'b1;
              w_state_nx = IDLE;
            end else begin
              w_frame_evt = 1'b1;
              w_state_nx  = BREAK;
            end
          end else begin
            w_tcnt_nx = r_tcnt + 1'b1;
          end
        end
        BREAK: begin
          if (w_rxs) w_state_nx = IDLE;
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  uk101_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_push  (w_push),
    .i_din   (r_shift),
    .i_pop   (rd_en),
    .o_dout  (rd_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign rd_valid  = !w_empty;
  assign w_ovr_evt = w_push && w_full && !(rd_en && rd_valid);

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_frame_evt)  r_ferr <= 1'b1;
      else if (err_clr) r_ferr <= 1'b0;
      if (w_ovr_evt)    r_ovr  <= 1'b1;
      else if (err_clr) r_ovr  <= 1'b0;
    end
  end

  assign framing_err = r_ferr;
  assign overrun     = r_ovr;

endmodule

// File: tb/tb_uk101_rx_fifo.sv
// Randomised bench for uk101_rx_fifo against a queue-based receiver model.
module tb_uk101_rx_fifo;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 25_000;
  localparam int DEPTH    = 8;
  localparam int DIV      = CLK_FREQ / (BAUD * 16);
  localparam int LW       = $clog2(DEPTH) + 1;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          rx;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_en;
  logic [LW-1:0] level;
  logic          framing_err;
  logic          overrun;
  logic          err_clr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] q[$];
  logic       m_ferr;
  logic       m_ovr;

  uk101_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .rx          (rx),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_en       (rd_en),
    .level       (level),
    .framing_err (framing_err),
    .overrun     (overrun),
    .err_clr     (err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  // Cycle index since the last reset edge; equals the divider phase modulo DIV.
  always @(posedge sys_clk) begin
    if (sys_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_level"}, 32'(level), 32'(q.size()));
    chk({tag, "_valid"}, 32'(rd_valid), 32'(q.size() != 0));
    chk({tag, "_ferr"},  32'(framing_err), 32'(m_ferr));
    chk({tag, "_ovr"},   32'(overrun), 32'(m_ovr));
    if (q.size() != 0) chk({tag, "_data"}, 32'(rd_data), 32'(q[0]));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Drives one 8N1 frame aligned to the clock; models the push/flag update at the
  // clock edge after the stop-bit sampling tick. rst_bit>=0 aborts with a reset
  // in the middle of that data bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit release_line,
                            input bit pop_on_push, input int rst_bit);
    int a, k0, p, n;
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    @(posedge sys_clk); #1;
    a  = cyc;
    k0 = a + 2;
    while (k0 % DIV != DIV - 1) k0++;
    p = k0 + 152 * DIV;
    for (int c = a; c < a + 160 * DIV; c++) begin
      n = (c - a) / (16 * DIV);
      if (rst_bit >= 0 && n == rst_bit + 1 && (c - a) % (16 * DIV) == 8 * DIV) begin
        sys_rst = 1'b1;
        rx      = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        check_all("rst_mid");
        return;
      end
      if (c == p) begin
        chk("pre_push_level", 32'(level), 32'(q.size()));
        if (pop_on_push && q.size() != 0) chk("pp_head", 32'(rd_data), 32'(q[0]));
      end
      if (c == p + 1) begin
        if (stop_ok) begin
          if (pop_on_push && q.size() != 0) void'(q.pop_front());
          if (q.size() < DEPTH) q.push_back(b);
          else                  m_ovr = 1'b1;
        end else begin
          m_ferr = 1'b1;
        end
        check_all("edge");
      end
      rx    = bits[n];
      rd_en = pop_on_push && (c == p);
      @(posedge sys_clk); #1;
    end
    rd_en = 1'b0;
    if (release_line) begin
      rx = 1'b1;
      idle(3 * DIV);
    end
  endtask

  task automatic do_pop();
    @(posedge sys_clk); #1;
    if (q.size() != 0) chk("pop_data", 32'(rd_data), 32'(q[0]));
    rd_en = 1'b1;
    @(posedge sys_clk); #1;
    rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    chk("pop_level", 32'(level), 32'(q.size()));
    chk("pop_valid", 32'(rd_valid), 32'(q.size() != 0));
  endtask

  task automatic do_clr();
    @(posedge sys_clk); #1;
    err_clr = 1'b1;
    @(posedge sys_clk); #1;
    err_clr = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    chk("clr_ferr", 32'(framing_err), 32'(m_ferr));
    chk("clr_ovr",  32'(overrun), 32'(m_ovr));
  endtask

  initial begin
    sys_rst = 1'b1;
    rx      = 1'b1;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
    idle(3);
    check_all("reset");
    sys_rst = 1'b0;
    idle(2 * DIV);

    send_frame(8'h55, 1'b1, 1'b1, 1'b0, -1);
    check_all("good");
    do_pop();

    @(posedge sys_clk); #1;
    rx = 1'b0;
    idle(3 * DIV);
    rx = 1'b1;
    idle(20 * DIV);
    check_all("glitch");

    send_frame(8'hA3, 1'b0, 1'b0, 1'b0, -1);
    check_all("frame");
    do_clr();
    idle(30 * 16 * DIV);
    check_all("break_hold");
    rx = 1'b1;
    idle(3 * DIV);
    do_clr();
    send_frame(8'h12, 1'b1, 1'b1, 1'b0, -1);
    check_all("after_break");
    do_pop();

    for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b1, 1'b1, 1'b0, -1);
    check_all("overrun");
    for (int i = 0; i < DEPTH; i++) do_pop();
    do_pop();
    do_clr();

    for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b1, 1'b0, -1);
    send_frame(8'h77, 1'b1, 1'b1, 1'b1, -1);
    check_all("pushpop_full");
    for (int i = 0; i < DEPTH; i++) do_pop();

    for (int i = 0; i < 24; i++) begin
      automatic int npop = $urandom_range(0, 2);
      send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 4) != 0, 1'b1, 1'b0, -1);
      check_all("rand");
      for (int j = 0; j < npop; j++) do_pop();
      if ($urandom_range(0, 3) == 0) do_clr();
    end

    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, -1);
    send_frame(8'hC3, 1'b1, 1'b1, 1'b0, -1);
    send_frame(8'hE7, 1'b1, 1'b1, 1'b0, 4);
    idle(4 * DIV);
    check_all("post_rst");
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, -1);
    check_all("after_rst");
    do_pop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
